// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit
// Description : BHT/BTB fetch predictor with execute-stage branch resolution,
//               misprediction detection and table training.
//               Optional counters enabled by defining BPU_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_f,
    output logic            pred_taken_f,
    output logic [XLEN-1:0] pred_target_f,
    input  logic            valid_e,
    input  logic            branch_e,
    input  logic            jump_e,
    input  logic [2:0]      funct3_e,
    input  logic [3:0]      alu_flags_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] target_e,
    input  logic            pred_taken_e,
    input  logic [XLEN-1:0] pred_target_e,
    output logic            pc_src_e,
    output logic            mispredict_e,
    output logic [XLEN-1:0] redirect_pc_e,
    output logic            illegal_cond_e
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int c_bht_iw = $clog2(BHT_ENTRIES);
    localparam int c_btb_iw = $clog2(BTB_ENTRIES);
    localparam int c_tag_w  = XLEN - c_btb_iw - 2;

    logic [1:0]             r_bht        [BHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] r_btb_valid;
    logic [BTB_ENTRIES-1:0] r_btb_jump;
    logic [c_tag_w-1:0]     r_btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        r_btb_target [BTB_ENTRIES];

    // ---------------- fetch-side lookup ----------------
    logic [c_bht_iw-1:0] w_f_bht_idx;
    logic [c_btb_iw-1:0] w_f_btb_idx;
    logic [c_tag_w-1:0]  w_f_tag;
    logic                w_f_hit;

    assign w_f_bht_idx   = pc_f[c_bht_iw+1:2];
    assign w_f_btb_idx   = pc_f[c_btb_iw+1:2];
    assign w_f_tag       = pc_f[XLEN-1:c_btb_iw+2];
    assign w_f_hit       = r_btb_valid[w_f_btb_idx] && (r_btb_tag[w_f_btb_idx] == w_f_tag);
    assign pred_taken_f  = w_f_hit && (r_btb_jump[w_f_btb_idx] || r_bht[w_f_bht_idx][1]);
    assign pred_target_f = pred_taken_f ? r_btb_target[w_f_btb_idx] : '0;

    // ---------------- execute-side resolution ----------------
    logic w_ovf, w_carry, w_neg, w_zero;
    logic w_cond, w_bad_f3, w_ctrl;
    logic [XLEN-1:0] w_pc_plus4;

    assign {w_ovf, w_carry, w_neg, w_zero} = alu_flags_e;

    // carry here means an unsigned borrow, i.e. a < b
    always_comb begin
        w_cond   = 1'b0;
        w_bad_f3 = 1'b0;
        case (funct3_e)
            3'b000:  w_cond = w_zero;
            3'b001:  w_cond = !w_zero;
            3'b100:  w_cond = w_neg ^ w_ovf;
            3'b101:  w_cond = !(w_neg ^ w_ovf);
            3'b110:  w_cond = w_carry;
            3'b111:  w_cond = !w_carry;
            default: w_bad_f3 = 1'b1;
        endcase
    end

    assign w_ctrl         = valid_e && (branch_e || jump_e);
    assign pc_src_e       = valid_e && (jump_e || (branch_e && w_cond));
    assign illegal_cond_e = valid_e && branch_e && w_bad_f3;
    assign w_pc_plus4     = pc_e + XLEN'(4);
    assign redirect_pc_e  = pc_src_e ? target_e : w_pc_plus4;

    // A predicted-taken non-control instruction is a BTB alias and must redirect
    assign mispredict_e = (w_ctrl && ((pc_src_e != pred_taken_e) ||
                                      (pc_src_e && (target_e != pred_target_e))))
                       || (valid_e && !branch_e && !jump_e && pred_taken_e);

    // ---------------- training ----------------
    logic [c_bht_iw-1:0] w_e_bht_idx;
    logic [c_btb_iw-1:0] w_e_btb_idx;
    logic                w_bht_upd, w_btb_upd;

    assign w_e_bht_idx = pc_e[c_bht_iw+1:2];
    assign w_e_btb_idx = pc_e[c_btb_iw+1:2];
    assign w_bht_upd   = w_ctrl && branch_e && !jump_e;
    assign w_btb_upd   = w_ctrl && pc_src_e;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
            r_btb_valid <= '0;
            r_btb_jump  <= '0;
        end else begin
            if (w_bht_upd) begin
                if (pc_src_e && (r_bht[w_e_bht_idx] != 2'b11)) begin
                    r_bht[w_e_bht_idx] <= r_bht[w_e_bht_idx] + 2'd1;
                end else if (!pc_src_e && (r_bht[w_e_bht_idx] != 2'b00)) begin
                    r_bht[w_e_bht_idx] <= r_bht[w_e_bht_idx] - 2'd1;
                end
            end
            if (w_btb_upd) begin
                r_btb_valid[w_e_btb_idx] <= 1'b1;
                r_btb_jump[w_e_btb_idx]  <= jump_e;
            end
        end
    end

    // Payload needs no reset: it is only observed behind a set valid bit
    always_ff @(posedge clk) begin
        if (w_btb_upd) begin
            r_btb_tag[w_e_btb_idx]    <= pc_e[XLEN-1:c_btb_iw+2];
            r_btb_target[w_e_btb_idx] <= target_e;
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_ctrl) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (mispredict_e) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

    logic w_unused;
    assign w_unused = &{1'b0, pc_f[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_unit
// Description : Directed self-checking bench for branch_predict_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

    localparam logic [2:0] c_beq  = 3'b000;
    localparam logic [2:0] c_bne  = 3'b001;
    localparam logic [2:0] c_blt  = 3'b100;
    localparam logic [2:0] c_bge  = 3'b101;
    localparam logic [2:0] c_bltu = 3'b110;
    localparam logic [2:0] c_bgeu = 3'b111;
    localparam logic [3:0] c_fz   = 4'b0001;
    localparam logic [3:0] c_fn   = 4'b0010;
    localparam logic [3:0] c_fc   = 4'b0100;
    localparam logic [3:0] c_fv   = 4'b1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        valid_e, branch_e, jump_e;
    logic [2:0]  funct3_e;
    logic [3:0]  alu_flags_e;
    logic [31:0] pc_e, target_e, pred_target_e;
    logic        pred_taken_e;
    logic        pc_src_e, mispredict_e, illegal_cond_e;
    logic [31:0] redirect_pc_e;
`ifdef BPU_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(64), .BTB_ENTRIES(16)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .pc_f           (pc_f),
        .pred_taken_f   (pred_taken_f),
        .pred_target_f  (pred_target_f),
        .valid_e        (valid_e),
        .branch_e       (branch_e),
        .jump_e         (jump_e),
        .funct3_e       (funct3_e),
        .alu_flags_e    (alu_flags_e),
        .pc_e           (pc_e),
        .target_e       (target_e),
        .pred_taken_e   (pred_taken_e),
        .pred_target_e  (pred_target_e),
        .pc_src_e       (pc_src_e),
        .mispredict_e   (mispredict_e),
        .redirect_pc_e  (redirect_pc_e),
        .illegal_cond_e (illegal_cond_e)
`ifdef BPU_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Fetch lookup with no execute activity; ends on the next falling edge
    task automatic lookup(input logic [31:0] pc, input logic exp_t,
                          input logic [31:0] exp_tgt, input string tag);
        valid_e = 1'b0;
        pc_f    = pc;
        #1;
        check({tag, "_taken"},  pred_taken_f,  exp_t);
        check({tag, "_target"}, pred_target_f, exp_tgt);
        @(negedge clk);
    endtask

    // One execute-stage instruction, checked before the training edge
    task automatic exec(input logic br, input logic jp, input logic [2:0] f3,
                        input logic [3:0] fl, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                        input logic exp_src, input logic exp_mis,
                        input logic [31:0] exp_redir, input string tag);
        logic exp_ill;
        valid_e       = 1'b1;
        branch_e      = br;
        jump_e        = jp;
        funct3_e      = f3;
        alu_flags_e   = fl;
        pc_e          = pc;
        target_e      = tgt;
        pred_taken_e  = pt;
        pred_target_e = ptgt;
        exp_ill       = br && (f3 == 3'b010 || f3 == 3'b011);
        #1;
        check({tag, "_src"},   pc_src_e,       exp_src);
        check({tag, "_mis"},   mispredict_e,   exp_mis);
        check({tag, "_redir"}, redirect_pc_e,  exp_redir);
        check({tag, "_ill"},   illegal_cond_e, exp_ill);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        pc_f = 32'h100; valid_e = 1'b0; branch_e = 1'b0; jump_e = 1'b0;
        funct3_e = 3'b000; alu_flags_e = 4'b0; pc_e = 32'h0; target_e = 32'h0;
        pred_taken_e = 1'b0; pred_target_e = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_src", pc_src_e, 1'b0);
        check("rst_mis", mispredict_e, 1'b0);
        check("rst_ill", illegal_cond_e, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // First BEQ trains BTB and bumps counter to 10
        lookup(32'h100, 1'b0, 32'h0, "rst_pred");
        exec(1, 0, c_beq, c_fz, 32'h100, 32'h180, 0, 32'h0, 1, 1, 32'h180, "beq");
        lookup(32'h100, 1'b1, 32'h180, "beq_learn");

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lookup(32'h100, 1'b0, 32'h0, "rst_clear");

        // BNE counter walk 01->10->11->11->10
        exec(1, 0, c_bne, 4'b0, 32'h200, 32'h240, 0, 32'h0,   1, 1, 32'h240, "bne1");
        lookup(32'h200, 1'b1, 32'h240, "bne1_p");
        exec(1, 0, c_bne, 4'b0, 32'h200, 32'h240, 1, 32'h240, 1, 0, 32'h240, "bne2");
        exec(1, 0, c_bne, 4'b0, 32'h200, 32'h240, 1, 32'h240, 1, 0, 32'h240, "bne3");
        lookup(32'h200, 1'b1, 32'h240, "bne3_p");
        exec(1, 0, c_bne, c_fz, 32'h200, 32'h240, 1, 32'h240, 0, 1, 32'h204, "bne4");
        lookup(32'h200, 1'b1, 32'h240, "bne4_p");

        // Condition decode
        exec(1, 0, c_bgeu, c_fz,        32'h1000, 32'h1100, 0, 32'h0, 1, 1, 32'h1100, "bgeu");
        exec(1, 0, c_bltu, c_fc,        32'h1004, 32'h1104, 0, 32'h0, 1, 1, 32'h1104, "bltu");
        exec(1, 0, c_bge,  c_fn | c_fv, 32'h1008, 32'h1108, 0, 32'h0, 1, 1, 32'h1108, "bge");
        exec(1, 0, c_blt,  c_fn | c_fv, 32'h100C, 32'h110C, 0, 32'h0, 0, 0, 32'h1010, "blt");
        exec(1, 0, 3'b010, c_fz,        32'h1010, 32'h1110, 0, 32'h0, 0, 0, 32'h1014, "ill");

        // Jump target learning and target mispredict
        exec(0, 1, 3'b000, 4'b0, 32'h300, 32'h400, 0, 32'h0,   1, 1, 32'h400, "jal");
        lookup(32'h300, 1'b1, 32'h400, "jal_p");
        exec(0, 1, 3'b000, 4'b0, 32'h300, 32'h480, 1, 32'h400, 1, 1, 32'h480, "jalr");
        lookup(32'h300, 1'b1, 32'h480, "jalr_p");
        exec(1, 1, c_beq, 4'b0, 32'h304, 32'h500, 0, 32'h0, 1, 1, 32'h500, "jmp_wins");

        // Aliasing and wrap-around
        lookup(32'h340, 1'b0, 32'h0, "alias_miss");
        exec(0, 0, 3'b000, 4'b0, 32'h340, 32'h999, 1, 32'h380, 0, 1, 32'h344, "alias_np");
        exec(1, 0, c_beq, 4'b0, 32'hFFFF_FFFC, 32'h10, 1, 32'h10, 0, 1, 32'h0, "wrap");

        // Reset during an update: write discarded, tables cleared
        pc_f = 32'h300; valid_e = 1'b1; branch_e = 1'b1; jump_e = 1'b0;
        funct3_e = c_beq; alu_flags_e = c_fz; pc_e = 32'h500; target_e = 32'h600;
        pred_taken_e = 1'b0; pred_target_e = 32'h0;
        reset = 1'b1;
        #1;
        check("rst_async_t", pred_taken_f, 1'b0);
        check("rst_async_tgt", pred_target_f, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        lookup(32'h500, 1'b0, 32'h0, "rst_upd");
        lookup(32'h300, 1'b0, 32'h0, "rst_btb");
`ifdef BPU_STATS_EN
        check("stat_br_0", stat_branches, 32'd0);
        check("stat_mp_0", stat_mispredicts, 32'd0);
`endif
        // Counter must restart at 01: one taken then one not-taken returns to not-taken
        exec(1, 0, c_beq, c_fz, 32'h200, 32'h280, 0, 32'h0,   1, 1, 32'h280, "ctr_t");
        lookup(32'h200, 1'b1, 32'h280, "ctr_p1");
        exec(1, 0, c_beq, 4'b0, 32'h200, 32'h280, 1, 32'h280, 0, 1, 32'h204, "ctr_nt");
        lookup(32'h200, 1'b0, 32'h0, "ctr_01");
        exec(1, 0, c_beq, 4'b0, 32'h700, 32'h800, 0, 32'h0, 0, 0, 32'h704, "nt1");
        exec(1, 0, c_beq, 4'b0, 32'h704, 32'h800, 0, 32'h0, 0, 0, 32'h708, "nt2");
        exec(1, 0, c_beq, 4'b0, 32'h708, 32'h800, 0, 32'h0, 0, 0, 32'h70C, "nt3");
        valid_e = 1'b0;
        #1;
`ifdef BPU_STATS_EN
        check("stat_br_5", stat_branches, 32'd5);
        check("stat_mp_2", stat_mispredicts, 32'd2);
        reset = 1'b1;
        #1;
        check("stat_br_rst", stat_branches, 32'd0);
        check("stat_mp_rst", stat_mispredicts, 32'd0);
        reset = 1'b0;
`endif
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
